// File: rtl/cpu_data_mem_arbiter_pkg.sv
// Shared constants for the CPU data memory arbiter and related multi-master
// blocks: port indices and the starvation limit used by the optional
// CPU-priority mode (CPU_DATA_MEM_ARB_CPU_PRIORITY_EN).
package cpu_data_mem_arbiter_pkg;

  localparam int       NUM_PORTS    = 2;
  localparam logic     PORT_CPU     = 1'b0;
  localparam logic     PORT_AUX     = 1'b1;
  localparam int       STARVE_W     = 4;
  localparam logic [STARVE_W-1:0] STARVE_LIMIT = 4'd15;

endpackage

// File: rtl/cpu_data_mem_rr_grant.sv
// 2-way round-robin grant cell.
//   i_req[1:0]    request per port
//   i_last_grant  index of the port granted most recently
//   o_gnt[1:0]    one-hot (or zero) grant, purely combinational
// A lone requester always wins; on a conflict the port that did not win
// last time is granted.
module cpu_data_mem_rr_grant
  import cpu_data_mem_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = i_req;
    if (&i_req) o_gnt = (i_last_grant == PORT_AUX) ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/cpu_data_mem_arbiter.sv
// Shares one single-port synchronous data memory (1-cycle read latency, a
// write cycle performs no read) between the CPU (port 0) and a secondary
// master (port 1). One access granted per cycle; read data returns to the
// issuing port with a registered valid one cycle after the grant.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   mN_req/we/addr/wdata             port N request (held until mN_gnt)
//   mN_gnt                           combinational accept
//   mN_rvalid/rdata                  read return, one-cycle strobe
//   mem_addr/write_enable/write_data to the memory
//   mem_read_data                    from the memory
//
// Build option: CPU_DATA_MEM_ARB_CPU_PRIORITY_EN gives port 0 fixed priority
// with a starvation counter that lets port 1 through after 15 lost cycles.
// Without it the arbiter is pure round-robin.
module cpu_data_mem_arbiter
  import cpu_data_mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SIZE       = 1024,
  parameter int ADDR_WIDTH = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_write_enable,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  // Extra bit so SIZE itself is representable when SIZE is a power of 2.
  localparam logic [ADDR_WIDTH:0] SIZE_W = (ADDR_WIDTH+1)'(SIZE);

  logic [NUM_PORTS-1:0]                 w_req, w_gnt, w_we, w_oob, w_rvalid;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] w_addr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] w_wdata, w_rdata;
  logic                                 w_any, w_sel, w_last_eff, w_rd;

  logic r_rd_pend, r_rd_port, r_rd_oob;

  // Gating with rst_n keeps both grants low throughout reset.
  assign w_req   = {m1_req, m0_req} & {NUM_PORTS{rst_n}};
  assign w_we    = {m1_we, m0_we};
  assign w_addr  = {m1_addr, m0_addr};
  assign w_wdata = {m1_wdata, m0_wdata};

`ifdef CPU_DATA_MEM_ARB_CPU_PRIORITY_EN
  logic [STARVE_W-1:0] r_starve;

  // Fixed priority expressed through the RR cell: pretend port 1 won last
  // time (port 0 wins) unless port 1 has starved to the limit.
  assign w_last_eff = (r_starve == STARVE_LIMIT) ? PORT_CPU : PORT_AUX;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   r_starve <= '0;
    else if (w_gnt[PORT_AUX])                     r_starve <= '0;
    else if (w_req[PORT_AUX] && r_starve != STARVE_LIMIT) r_starve <= r_starve + 1'b1;
  end
`else
  logic r_last_grant;

  assign w_last_eff = r_last_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_last_grant <= PORT_AUX;
    else if (w_any) r_last_grant <= w_sel;
  end
`endif

  cpu_data_mem_rr_grant u_rr (
    .i_req        (w_req),
    .i_last_grant (w_last_eff),
    .o_gnt        (w_gnt)
  );

  assign w_any = |w_gnt;
  assign w_sel = w_gnt[PORT_AUX];
  assign w_rd  = w_any & ~w_we[w_sel];

  // Memory side: muxed from the granted port, zero when idle.
  assign mem_addr         = w_any ? w_addr[w_sel]  : '0;
  assign mem_write_data   = w_any ? w_wdata[w_sel] : '0;
  assign mem_write_enable = w_any & w_we[w_sel] & ~w_oob[w_sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend <= 1'b0;
      r_rd_port <= PORT_CPU;
      r_rd_oob  <= 1'b0;
    end else begin
      r_rd_pend <= w_rd;
      if (w_rd) begin
        r_rd_port <= w_sel;
        r_rd_oob  <= w_oob[w_sel];
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    // Out-of-range only arises when SIZE is not a power of 2.
    assign w_oob[g]    = {1'b0, w_addr[g]} >= SIZE_W;
    assign w_rvalid[g] = r_rd_pend & (r_rd_port == 1'(g));
    assign w_rdata[g]  = (w_rvalid[g] & ~r_rd_oob) ? mem_read_data : '0;
  end

  assign m0_gnt    = w_gnt[PORT_CPU];
  assign m1_gnt    = w_gnt[PORT_AUX];
  assign m0_rvalid = w_rvalid[PORT_CPU];
  assign m1_rvalid = w_rvalid[PORT_AUX];
  assign m0_rdata  = w_rdata[PORT_CPU];
  assign m1_rdata  = w_rdata[PORT_AUX];

endmodule

// File: tb/tb_cpu_data_mem_arbiter.sv
// Directed bench for cpu_data_mem_arbiter with SIZE=1000 so out-of-range
// addresses exist. Includes a behavioural 1-cycle-latency memory.
module tb_cpu_data_mem_arbiter;

  localparam int DW = 16;
  localparam int SZ = 1000;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_write_enable;
  logic [DW-1:0] mem_write_data, mem_read_data;

  logic [DW-1:0] mem [0:1023];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cpu_data_mem_arbiter #(.DATA_WIDTH(DW), .SIZE(SZ), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_write_enable(mem_write_enable),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  // Single-port synchronous memory: a write cycle does not update read data.
  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_addr] <= mem_write_data;
    else                  mem_read_data <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                     input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[20]   = 16'h2020;
    mem[21]   = 16'h2121;
    mem[1010] = 16'hDEAD;
    mem_read_data = '0;

    // Reset held with both ports requesting.
    rst_n = 1'b0;
    drv(1, 0, 10'd0, 16'h0, 1, 0, 10'd0, 16'h0);
    repeat (3) tick;
    chk("rst_gnt0", m0_gnt, 0);
    chk("rst_gnt1", m1_gnt, 0);
    chk("rst_rv0", m0_rvalid, 0);
    chk("rst_rv1", m1_rvalid, 0);
    chk("rst_rd0", m0_rdata, 0);
    chk("rst_rd1", m1_rdata, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_gnt0", m0_gnt, 1);
    chk("rel_gnt1", m1_gnt, 0);
    tick;
    chk("rel_rv0", m0_rvalid, 1);
    chk("rel_rv1", m1_rvalid, 0);

    // Single port: write then read back.
    drv(1, 1, 10'd5, 16'hBEEF, 0, 0, 10'd0, 16'h0);
    chk("sp_wgnt", m0_gnt, 1);
    chk("sp_we", mem_write_enable, 1);
    chk("sp_addr", mem_addr, 5);
    chk("sp_wdata", mem_write_data, 16'hBEEF);
    tick;
    chk("sp_wr_norv", m0_rvalid, 0);
    drv(1, 0, 10'd5, 16'h0, 0, 0, 10'd0, 16'h0);
    chk("sp_rgnt", m0_gnt, 1);
    chk("sp_rd_we", mem_write_enable, 0);
    tick;
    chk("sp_rv0", m0_rvalid, 1);
    chk("sp_rdata", m0_rdata, 16'hBEEF);
    chk("sp_rv1", m1_rvalid, 0);
    drv(0, 0, 10'd0, 16'h0, 0, 0, 10'd0, 16'h0);
    chk("idle_gnt", {m1_gnt, m0_gnt}, 0);
    chk("idle_addr", mem_addr, 0);
    chk("idle_wdata", mem_write_data, 0);
    tick;
    chk("sp_rv_once", m0_rvalid, 0);

    // Write on port 1, read on port 0 the very next cycle.
    drv(0, 0, 10'd0, 16'h0, 1, 1, 10'd7, 16'h1234);
    chk("raw_wgnt1", m1_gnt, 1);
    tick;
    chk("raw_wr_norv", m1_rvalid, 0);
    drv(1, 0, 10'd7, 16'h0, 0, 0, 10'd0, 16'h0);
    chk("raw_rgnt0", m0_gnt, 1);
    tick;
    chk("raw_rv0", m0_rvalid, 1);
    chk("raw_rdata", m0_rdata, 16'h1234);

    // Lone port-1 read.
    drv(0, 0, 10'd0, 16'h0, 1, 0, 10'd21, 16'h0);
    chk("p1_gnt", m1_gnt, 1);
    tick;
    chk("p1_rv1", m1_rvalid, 1);
    chk("p1_rdata", m1_rdata, 16'h2121);
    chk("p1_rv0", m0_rvalid, 0);

    // Out-of-range: write dropped, read returns zero.
    drv(1, 1, 10'd1010, 16'h5555, 0, 0, 10'd0, 16'h0);
    chk("oob_wgnt", m0_gnt, 1);
    chk("oob_we", mem_write_enable, 0);
    tick;
    drv(1, 0, 10'd1010, 16'h0, 0, 0, 10'd0, 16'h0);
    chk("oob_rgnt", m0_gnt, 1);
    tick;
    chk("oob_rv", m0_rvalid, 1);
    chk("oob_rdata", m0_rdata, 0);

    // Reset pulsed while a read is returning.
    drv(1, 0, 10'd5, 16'h0, 0, 0, 10'd0, 16'h0);
    tick;
    chk("mid_rv_pre", m0_rvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rv_rst", m0_rvalid, 0);
    drv(1, 0, 10'd20, 16'h0, 1, 0, 10'd21, 16'h0);
    chk("mid_gnt_rst", {m1_gnt, m0_gnt}, 0);
    tick;
    rst_n = 1'b1;
    #1;
    chk("mid_rv0_post", m0_rvalid, 0);
    chk("mid_rv1_post", m1_rvalid, 0);

`ifdef CPU_DATA_MEM_ARB_CPU_PRIORITY_EN
    // Both requesting: 15 CPU grants, then one port-1 grant, repeating.
    for (int i = 0; i < 32; i++) begin
      logic e1;
      e1 = (i == 15) || (i == 31);
      chk($sformatf("pri_gnt0_%0d", i), m0_gnt, !e1);
      chk($sformatf("pri_gnt1_%0d", i), m1_gnt, e1);
      tick;
    end
`else
    // Both requesting: grants alternate starting with port 0.
    for (int i = 0; i < 6; i++) begin
      logic e0;
      e0 = (i % 2) == 0;
      chk($sformatf("rr_gnt0_%0d", i), m0_gnt, e0);
      chk($sformatf("rr_gnt1_%0d", i), m1_gnt, !e0);
      chk($sformatf("rr_addr_%0d", i), mem_addr, e0 ? 10'd20 : 10'd21);
      tick;
      chk($sformatf("rr_rv0_%0d", i), m0_rvalid, e0);
      chk($sformatf("rr_rv1_%0d", i), m1_rvalid, !e0);
      chk($sformatf("rr_rd0_%0d", i), m0_rdata, e0 ? 16'h2020 : 16'h0);
      chk($sformatf("rr_rd1_%0d", i), m1_rdata, e0 ? 16'h0 : 16'h2121);
    end
`endif

    drv(0, 0, 10'd0, 16'h0, 0, 0, 10'd0, 16'h0);
    tick;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
